// File: rtl/axi_mem_responder_if.sv
// AXI4 channel bundle shared between the memory responder and the masters that drive it.
interface t_AXI4 #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 42,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [LEN_WIDTH-1:0]    awlen;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [LEN_WIDTH-1:0]    arlen;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: one outstanding write and one outstanding read burst, all bursts INCR,
// byte-strobed writes into an unreset word array, two-cycle read latency.
module axi_mem_responder #(
    parameter int unsigned DATA_WIDTH    = 256,
    parameter int unsigned ADDR_WIDTH    = 42,
    parameter int unsigned MEM_ADDR_BITS = 9
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    t_AXI4.slave        axi_if,
    output logic [15:0] o_wr_bursts,
    output logic [15:0] o_rd_bursts,
    output logic        o_error
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned BB     = $clog2(STRB_W);
    localparam int unsigned DEPTH  = 1 << MEM_ADDR_BITS;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned ID_W   = 8;

    typedef logic [MEM_ADDR_BITS-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t          w_state_q;
    logic              awready_q, wready_q, bvalid_q, w_err_q, err_q;
    logic [1:0]        bresp_q;
    logic [ID_W-1:0]   bid_q;
    logic [LEN_W-1:0]  awlen_q, wbeat_q;
    idx_t              w_idx_q;
    logic [15:0]       wr_cnt_q;

    r_state_t          r_state_q;
    logic              arready_q, rvalid_q, rlast_q;
    logic [ID_W-1:0]   rid_q;
    logic [LEN_W-1:0]  arlen_q, rbeat_q;
    idx_t              r_idx_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [15:0]       rd_cnt_q;

    logic w_hs_c, w_last_beat_c, w_mismatch_c;
    logic [ADDR_WIDTH-1:0] unused_awaddr;
    logic [ADDR_WIDTH-1:0] unused_araddr;

    // Only the word-index slice of each address is decoded.
    assign unused_awaddr = axi_if.awaddr;
    assign unused_araddr = axi_if.araddr;

    assign w_hs_c        = (w_state_q == W_DATA) && axi_if.wvalid && wready_q;
    assign w_last_beat_c = (wbeat_q == awlen_q);
    assign w_mismatch_c  = (axi_if.wlast != w_last_beat_c);

    // Write channel FSM
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            awlen_q   <= '0;
            wbeat_q   <= '0;
            w_idx_q   <= '0;
            w_err_q   <= 1'b0;
            err_q     <= 1'b0;
            wr_cnt_q  <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (axi_if.awvalid && awready_q) begin
                        bid_q     <= axi_if.awid;
                        awlen_q   <= axi_if.awlen;
                        w_idx_q   <= axi_if.awaddr[BB +: MEM_ADDR_BITS];
                        wbeat_q   <= '0;
                        w_err_q   <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end else if (axi_if.wvalid) begin
                        err_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs_c) begin
                        w_idx_q <= idx_t'(w_idx_q + 1'b1);
                        wbeat_q <= LEN_W'(wbeat_q + 1'b1);
                        if (w_mismatch_c) begin
                            w_err_q <= 1'b1;
                            err_q   <= 1'b1;
                        end
                        if (w_last_beat_c) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (w_err_q || w_mismatch_c) ? 2'b10 : 2'b00;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_if.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wr_cnt_q  <= 16'(wr_cnt_q + 1'b1);
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Storage has no reset; a beat coinciding with reset is dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && w_hs_c) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (axi_if.wstrb[b]) begin
                    mem[w_idx_q][b*8 +: 8] <= axi_if.wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read channel FSM; R_FETCH is the memory access cycle before the first beat.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            arlen_q   <= '0;
            rbeat_q   <= '0;
            r_idx_q   <= '0;
            rdata_q   <= '0;
            rd_cnt_q  <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (axi_if.arvalid && arready_q) begin
                        rid_q     <= axi_if.arid;
                        arlen_q   <= axi_if.arlen;
                        r_idx_q   <= axi_if.araddr[BB +: MEM_ADDR_BITS];
                        arready_q <= 1'b0;
                        r_state_q <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rdata_q   <= mem[r_idx_q];
                    r_idx_q   <= idx_t'(r_idx_q + 1'b1);
                    rbeat_q   <= '0;
                    rlast_q   <= (arlen_q == '0);
                    rvalid_q  <= 1'b1;
                    r_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (axi_if.rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rd_cnt_q  <= 16'(rd_cnt_q + 1'b1);
                            r_state_q <= R_IDLE;
                        end else begin
                            rdata_q <= mem[r_idx_q];
                            r_idx_q <= idx_t'(r_idx_q + 1'b1);
                            rbeat_q <= LEN_W'(rbeat_q + 1'b1);
                            rlast_q <= (LEN_W'(rbeat_q + 1'b1) == arlen_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign axi_if.awready = awready_q;
    assign axi_if.wready  = wready_q;
    assign axi_if.bvalid  = bvalid_q;
    assign axi_if.bresp   = bresp_q;
    assign axi_if.bid     = bid_q;
    assign axi_if.arready = arready_q;
    assign axi_if.rvalid  = rvalid_q;
    assign axi_if.rlast   = rlast_q;
    assign axi_if.rid     = rid_q;
    assign axi_if.rdata   = rdata_q;
    assign axi_if.rresp   = 2'b00;

    assign o_wr_bursts = wr_cnt_q;
    assign o_rd_bursts = rd_cnt_q;
    assign o_error     = err_q;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: table of write/readback bursts plus hand-built corner sequences.
module tb_axi_mem_responder;
    localparam int unsigned DW  = 256;
    localparam int unsigned AW  = 42;
    localparam int unsigned MAB = 9;

    typedef struct {
        logic [AW-1:0] waddr;
        logic [AW-1:0] raddr;
        logic [7:0]    len;
        logic [DW-1:0] base;
        logic [1:0]    exp_bresp;
        logic [DW-1:0] exp_first;
        logic [DW-1:0] exp_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] wr_bursts, rd_bursts;
    logic        error;

    int checks = 0;
    int errors = 0;
    int exp_wr = 0;
    int exp_rd = 0;

    logic [DW-1:0] rd_data [16];
    logic          rd_last [16];
    int            rd_beats;
    int            rd_lat;
    logic [1:0]    last_bresp;
    vec_t          vecs [4];

    t_AXI4 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(8), .ID_WIDTH(8)) axi ();

    axi_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_ADDR_BITS(MAB)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .axi_if      (axi),
        .o_wr_bursts (wr_bursts),
        .o_rd_bursts (rd_bursts),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [DW-1:0] base, input logic [31:0] strb, input int wlast_beat);
        int n;
        @(negedge clk);
        axi.awvalid = 1'b1;
        axi.awaddr  = addr;
        axi.awlen   = len;
        axi.awid    = 8'h5A;
        n = 0;
        while (!axi.awready && n < 20) begin @(negedge clk); n++; end
        chk("aw_accept", DW'(axi.awready), DW'(1));
        @(negedge clk);
        axi.awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            axi.wvalid = 1'b1;
            axi.wdata  = base + DW'(k);
            axi.wstrb  = strb;
            axi.wlast  = (k == wlast_beat);
            n = 0;
            while (!axi.wready && n < 20) begin @(negedge clk); n++; end
            chk("w_accept", DW'(axi.wready), DW'(1));
            @(negedge clk);
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        axi.bready = 1'b1;
        n = 0;
        while (!axi.bvalid && n < 20) begin @(negedge clk); n++; end
        chk("b_valid", DW'(axi.bvalid), DW'(1));
        chk("b_id", DW'(axi.bid), DW'(8'h5A));
        last_bresp = axi.bresp;
        if (axi.bvalid) exp_wr++;
        @(negedge clk);
        axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [7:0] len, input bit rnd);
        int            n;
        logic          stalled;
        logic          done;
        logic [DW-1:0] held_d;
        logic          held_l;
        @(negedge clk);
        axi.arvalid = 1'b1;
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arid    = 8'hC3;
        n = 0;
        while (!axi.arready && n < 20) begin @(negedge clk); n++; end
        chk("ar_accept", DW'(axi.arready), DW'(1));
        @(negedge clk);
        axi.arvalid = 1'b0;
        rd_lat = 1;
        while (!axi.rvalid && rd_lat < 20) begin @(negedge clk); rd_lat++; end
        rd_beats = 0;
        stalled  = 1'b0;
        held_d   = '0;
        held_l   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (stalled) begin
                chk("r_hold_valid", DW'(axi.rvalid), DW'(1));
                chk("r_hold_data", axi.rdata, held_d);
                chk("r_hold_last", DW'(axi.rlast), DW'(held_l));
            end
            if (rd_beats == 0 && !stalled) begin
                chk("r_id", DW'(axi.rid), DW'(8'hC3));
                chk("r_resp", DW'(axi.rresp), DW'(2'b00));
            end
            axi.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi.rready) begin
                if (rd_beats < 16) begin
                    rd_data[rd_beats] = axi.rdata;
                    rd_last[rd_beats] = axi.rlast;
                end
                rd_beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held_d  = axi.rdata;
                held_l  = axi.rlast;
            end
            done = axi.rready && axi.rlast;
            @(negedge clk);
            if (done) begin
                exp_rd++;
                break;
            end
            if (!axi.rvalid) break;
        end
        axi.rready = 1'b0;
    endtask

    task automatic check_burst(input string tag, input logic [7:0] len, input logic [DW-1:0] base);
        chk({tag, "_beats"}, DW'(rd_beats), DW'(int'(len) + 1));
        for (int b = 0; b <= int'(len) && b < 16; b++) begin
            chk({tag, "_data"}, rd_data[b], base + DW'(b));
            chk({tag, "_last"}, DW'(rd_last[b]), DW'(b == int'(len)));
        end
    endtask

    initial begin
        logic [DW-1:0] strb_exp;

        vecs[0] = '{42'h40,          42'h40,   8'd3, 256'h1,    2'b00, 256'h1,    256'h4};
        vecs[1] = '{42'h1000,        42'h1000, 8'd0, 256'hDEAD, 2'b00, 256'hDEAD, 256'hDEAD};
        vecs[2] = '{42'h2020,        42'h2020, 8'd5,
                    {8{32'h0102_0304}}, 2'b00, {8{32'h0102_0304}}, {{7{32'h0102_0304}}, 32'h0102_0309}};
        vecs[3] = '{42'h3FF0_0000_C00, 42'hC00, 8'd1, 256'h5555, 2'b00, 256'h5555, 256'h5556};

        rst_n       = 1'b0;
        axi.awvalid = 1'b0; axi.awaddr = '0; axi.awlen = '0; axi.awid = '0;
        axi.wvalid  = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0; axi.araddr = '0; axi.arlen = '0; axi.arid = '0;
        axi.rready  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_awready", DW'(axi.awready), DW'(0));
        chk("rst_arready", DW'(axi.arready), DW'(0));
        chk("rst_wready", DW'(axi.wready), DW'(0));
        chk("rst_bvalid", DW'(axi.bvalid), DW'(0));
        chk("rst_rvalid", DW'(axi.rvalid), DW'(0));
        chk("rst_rlast", DW'(axi.rlast), DW'(0));
        chk("rst_bresp", DW'(axi.bresp), DW'(0));
        chk("rst_error", DW'(error), DW'(0));
        chk("rst_wr_cnt", DW'(wr_bursts), DW'(0));
        chk("rst_rd_cnt", DW'(rd_bursts), DW'(0));

        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready", DW'(axi.awready), DW'(1));
        chk("rel_arready", DW'(axi.arready), DW'(1));

        // Table-driven write/readback bursts
        for (int i = 0; i < 4; i++) begin
            axi_write(vecs[i].waddr, vecs[i].len, vecs[i].base, 32'hFFFF_FFFF, int'(vecs[i].len));
            chk("vec_bresp", DW'(last_bresp), DW'(vecs[i].exp_bresp));
            axi_read(vecs[i].raddr, vecs[i].len, 1'b0);
            chk("vec_latency", DW'(rd_lat), DW'(2));
            chk("vec_first", rd_data[0], vecs[i].exp_first);
            chk("vec_last_data", rd_data[int'(vecs[i].len)], vecs[i].exp_last);
            check_burst("vec", vecs[i].len, vecs[i].base);
            chk("vec_wr_cnt", DW'(wr_bursts), DW'(i + 1));
            chk("vec_rd_cnt", DW'(rd_bursts), DW'(i + 1));
        end
        chk("vec_error", DW'(error), DW'(0));

        // Partial strobe over an all-ones word
        axi_write(42'h640, 8'd0, {DW{1'b1}}, 32'hFFFF_FFFF, 0);
        axi_write(42'h640, 8'd0, '0, 32'h0000_000F, 0);
        axi_read(42'h640, 8'd0, 1'b0);
        strb_exp = {{224{1'b1}}, 32'h0};
        chk("strb_data", rd_data[0], strb_exp);

        // Index wrap from the top word to word 0
        axi_write(42'h3FE0, 8'd1, 256'hA1, 32'hFFFF_FFFF, 1);
        axi_read(42'h0, 8'd0, 1'b0);
        chk("wrap_word0", rd_data[0], 256'hA2);
        axi_read(42'h3FE0, 8'd1, 1'b0);
        check_burst("wrap_rd", 8'd1, 256'hA1);

        // Eight-beat read under random back-pressure
        axi_write(42'h800, 8'd7, 256'h70, 32'hFFFF_FFFF, 7);
        axi_read(42'h800, 8'd7, 1'b1);
        chk("stall_latency", DW'(rd_lat), DW'(2));
        check_burst("stall", 8'd7, 256'h70);
        chk("cnt_wr", DW'(wr_bursts), DW'(exp_wr));
        chk("cnt_rd", DW'(rd_bursts), DW'(exp_rd));

        // Early wlast gives SLVERR and a sticky error
        axi_write(42'h900, 8'd2, 256'h90, 32'hFFFF_FFFF, 1);
        chk("early_last_bresp", DW'(last_bresp), DW'(2'b10));
        chk("early_last_error", DW'(error), DW'(1));
        axi_write(42'hA00, 8'd0, 256'hAA, 32'hFFFF_FFFF, 0);
        chk("good_after_err_bresp", DW'(last_bresp), DW'(2'b00));
        chk("error_sticky", DW'(error), DW'(1));

        // Reset during beat 2 of a 4-beat write
        @(negedge clk);
        axi.awvalid = 1'b1; axi.awaddr = 42'h1900; axi.awlen = 8'd3; axi.awid = 8'h11;
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wstrb   = 32'hFFFF_FFFF;
        axi.wlast   = 1'b0;
        axi.wvalid  = 1'b1; axi.wdata = 256'hB0;
        @(negedge clk);
        axi.wdata = 256'hB1;
        @(negedge clk);
        axi.wdata = 256'hB2;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_bvalid", DW'(axi.bvalid), DW'(0));
        chk("mid_rst_wr_cnt", DW'(wr_bursts), DW'(0));
        chk("mid_rst_rd_cnt", DW'(rd_bursts), DW'(0));
        chk("mid_rst_error", DW'(error), DW'(0));
        chk("mid_rst_awready", DW'(axi.awready), DW'(0));
        exp_wr = 0;
        exp_rd = 0;
        axi.wvalid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", DW'(axi.awready), DW'(1));
        chk("post_rst_arready", DW'(axi.arready), DW'(1));
        repeat (3) @(negedge clk);
        chk("post_rst_no_b", DW'(axi.bvalid), DW'(0));
        axi_read(42'h1900, 8'd1, 1'b0);
        check_burst("kept_partial", 8'd1, 256'hB0);
        axi_read(42'h40, 8'd3, 1'b0);
        check_burst("kept_old", 8'd3, 256'h1);
        chk("post_rst_rd_cnt", DW'(rd_bursts), DW'(2));
        chk("post_rst_wr_cnt", DW'(wr_bursts), DW'(0));

        // Stray W beat with no write burst open
        @(negedge clk);
        axi.wvalid = 1'b1; axi.wdata = 256'hEE; axi.wlast = 1'b1;
        @(negedge clk);
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        @(negedge clk);
        chk("stray_w_error", DW'(error), DW'(1));
        chk("stray_w_no_b", DW'(axi.bvalid), DW'(0));
        axi_read(42'h40, 8'd0, 1'b0);
        chk("stray_w_discarded", rd_data[0], 256'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 256: AXI data width in bits; legal values are 64, 128, 256 and 512.
REQ-002 Parameter ADDR_WIDTH, default 42: AXI address width in bits.
REQ-003 Parameter MEM_ADDR_BITS, default 9: log2 of the internal memory depth in words.
REQ-004 Port i_clk, input, 1: clock; all logic is on the rising edge.
REQ-005 Port i_reset_n, input, 1: reset, synchronous, active-low.
REQ-006 Port axi_if, interface, t_AXI4 slave modport (LEN_WIDTH 8, ID_WIDTH 8): AXI4 responder port driven by a master such as the packet generator/checker.
REQ-007 Port o_wr_bursts, output, 16: count of completed write bursts (B handshakes).
REQ-008 Port o_rd_bursts, output, 16: count of completed read bursts (R handshakes with rlast).
REQ-009 Port o_error, output, 1: sticky protocol error flag.

Function
REQ-010 Memory SHALL hold 2^MEM_ADDR_BITS words of DATA_WIDTH bits, with no reset of contents.
REQ-011 Word index SHALL be addr[BB +: MEM_ADDR_BITS], where BB = log2(DATA_WIDTH/8); upper address bits are ignored.
REQ-012 Every burst SHALL be treated as INCR regardless of the burst field; the index increments by 1 per beat and wraps modulo 2^MEM_ADDR_BITS.
REQ-013 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP; at most one write burst is outstanding.
REQ-014 W_IDLE: awready=1; an AW handshake latches awid, awlen and the start index, then the FSM goes to W_DATA; wready=0 in W_IDLE.
REQ-015 W_DATA: wready=1; each W handshake writes the bytes enabled by wstrb at the current index, then increments the index and beat count.
REQ-016 The write burst SHALL end on the beat where the beat count equals awlen; the FSM then goes to W_RESP.
REQ-017 If wlast disagrees with the beat count on any beat, bresp SHALL be 2'b10 (SLVERR) and o_error is set; otherwise bresp=2'b00.
REQ-018 W_RESP: bvalid=1 and bid=latched awid are held until bready; on the handshake the FSM returns to W_IDLE and o_wr_bursts increments.
REQ-019 Read FSM states SHALL be R_IDLE, R_FETCH and R_DATA; at most one read burst is outstanding; arready=1 only in R_IDLE.
REQ-020 Read latency: AR handshake in cycle N gives rvalid=1 with data for the first beat in cycle N+2.
REQ-021 R_DATA: rid=latched arid and rresp=2'b00; rlast=1 on beat arlen.
REQ-022 rdata, rlast and rvalid SHALL be held stable while rready=0; the next beat follows with no bubble under continuous rready.
REQ-023 The rlast handshake SHALL return the read FSM to R_IDLE and increment o_rd_bursts.
REQ-024 Read and write paths are independent; a same-cycle read and write to the same word returns the old data.
REQ-025 Counters SHALL wrap from 16'hFFFF to 0.
REQ-026 o_error SHALL be set on a wlast mismatch or on a W beat received in W_IDLE (that beat is discarded); it clears only on reset.

Reset
REQ-027 While i_reset_n=0: FSMs go to W_IDLE/R_IDLE; awready, wready, bvalid, arready, rvalid, rlast and o_error are 0; counters are 0; bresp and rresp are 0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst with no B or R response; memory contents are retained.
REQ-029 awready and arready SHALL assert in the first cycle after i_reset_n rises.

Verification
REQ-030 Write awaddr=0x40, awlen=3, all-ones wstrb, data 1..4 (DATA_WIDTH=256), then read araddr=0x40, arlen=3 -> rdata 1,2,3,4; rlast on beat 3; bresp=0; both counters=1.
REQ-031 Write one beat with wstrb=0x0000000F over a word holding all-ones with data 0 -> read returns only bytes 0-3 zero, all other bytes 0xFF.
REQ-032 MEM_ADDR_BITS=9, write starting at index 511 with awlen=1 -> the second beat lands at index 0, confirmed by readback.
REQ-033 Write awlen=2 with wlast asserted on beat 1 -> bresp=2'b10, o_error=1 and stays 1 until reset.
REQ-034 Read arlen=7 with rready toggled randomly -> all 8 beats arrive in order with data unchanged across stalls; first rvalid occurs 2 cycles after AR.
REQ-035 Assert reset during beat 2 of a 4-beat write -> no bvalid, counters=0, awready=1 the cycle after release, and earlier-written words are intact.
